// File: rtl/shift_out_reg.sv
// Parallel-in, serial-out transmit shifter: one word in via valid/ready,
// emitted MSB-first, one bit per ena tick, with a done pulse after the last bit.
module shift_out_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             ena,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;
   logic             accept;
   logic             advance;
   logic             last_bit;

   assign accept   = (state == IDLE)  && load_valid;
   assign advance  = (state == SHIFT) && ena;
   assign last_bit = (cnt == CW'(1));

   always_ff @(posedge clk) begin
      if (clr) state <= IDLE;
      else     state <= state_nxt;
   end

   // Outputs decode purely from registered state; the unused encoding falls back to IDLE.
   always_comb begin
      state_nxt  = IDLE;
      load_ready = 1'b0;
      ser_out    = 1'b0;
      ser_valid  = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            load_ready = 1'b1;
            state_nxt  = load_valid ? SHIFT : IDLE;
         end
         SHIFT: begin
            ser_out   = shreg[WIDTH-1];
            ser_valid = 1'b1;
            busy      = 1'b1;
            state_nxt = (ena && last_bit) ? DONE : SHIFT;
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         shreg <= '0;
         cnt   <= '0;
      end else if (accept) begin
         shreg <= load_data;
         cnt   <= CW'(WIDTH);
      end else if (advance) begin
         shreg <= {shreg[WIDTH-2:0], 1'b0};
         cnt   <= cnt - 1'b1;
      end
   end

endmodule

// File: tb/tb_shift_out_reg.sv
// Directed bench for shift_out_reg: vector table on an 8-bit build plus
// hand-written back-to-back, 2-bit and 32-bit sequences.
module tb_shift_out_reg;

   logic        clk = 1'b0;
   logic        clr, ena;
   logic        lv8, lv2, lv32;
   logic [7:0]  d8;
   logic [1:0]  d2;
   logic [31:0] d32;
   logic        rdy8, so8, sv8, bsy8, dn8;
   logic        rdy2, so2, sv2, bsy2, dn2;
   logic        rdy32, so32, sv32, bsy32, dn32;

   always #5 clk = ~clk;

   shift_out_reg #(.WIDTH(8)) u8 (
      .clk(clk), .clr(clr), .ena(ena), .load_valid(lv8), .load_data(d8),
      .load_ready(rdy8), .ser_out(so8), .ser_valid(sv8), .busy(bsy8), .done(dn8));
   shift_out_reg #(.WIDTH(2)) u2 (
      .clk(clk), .clr(clr), .ena(ena), .load_valid(lv2), .load_data(d2),
      .load_ready(rdy2), .ser_out(so2), .ser_valid(sv2), .busy(bsy2), .done(dn2));
   shift_out_reg #(.WIDTH(32)) u32 (
      .clk(clk), .clr(clr), .ena(ena), .load_valid(lv32), .load_data(d32),
      .load_ready(rdy32), .ser_out(so32), .ser_valid(sv32), .busy(bsy32), .done(dn32));

   // expected = {load_ready, ser_out, ser_valid, busy, done}
   localparam logic [4:0] IDL = 5'b10000;
   localparam logic [4:0] S1  = 5'b01110;
   localparam logic [4:0] S0  = 5'b00110;
   localparam logic [4:0] DN  = 5'b00011;

   typedef struct {
      logic       c;
      logic       e;
      logic       lv;
      logic [7:0] d;
      logic [4:0] x;
   } vec_t;

   vec_t tv[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic add(input logic c, input logic e, input logic lv,
                      input logic [7:0] d, input logic [4:0] x);
      vec_t v;
      v.c = c; v.e = e; v.lv = lv; v.d = d; v.x = x;
      tv.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [4:0] got,
                      input logic [4:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d]: got {rdy,so,sv,busy,done}=%b want %b", name, idx, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] o8();
      return {rdy8, so8, sv8, bsy8, dn8};
   endfunction
   function automatic logic [4:0] o2();
      return {rdy2, so2, sv2, bsy2, dn2};
   endfunction
   function automatic logic [4:0] o32();
      return {rdy32, so32, sv32, bsy32, dn32};
   endfunction

   initial begin
      logic [31:0] w32;

      // basic A5 word, with load_valid poked during SHIFT/DONE to show it is ignored
      add(0,1,1,8'hA5,S1); add(0,1,0,8'h00,S0); add(0,1,1,8'h3C,S1); add(0,1,0,8'h00,S0);
      add(0,1,0,8'h00,S0); add(0,1,0,8'h00,S1); add(0,1,0,8'h00,S0); add(0,1,0,8'h00,S1);
      add(0,1,1,8'h77,DN); add(0,1,1,8'h77,IDL); add(0,0,0,8'h00,IDL);
      // C3 with ena stalls
      add(0,1,1,8'hC3,S1); add(0,0,0,8'h00,S1); add(0,0,0,8'h00,S1); add(0,1,0,8'h00,S1);
      add(0,1,0,8'h00,S0); add(0,0,0,8'h00,S0); add(0,1,0,8'h00,S0); add(0,1,0,8'h00,S0);
      add(0,0,0,8'h00,S0); add(0,1,0,8'h00,S0); add(0,1,0,8'h00,S1); add(0,1,0,8'h00,S1);
      add(0,0,0,8'h00,S1); add(0,1,0,8'h00,DN); add(0,0,0,8'h00,IDL);
      // 5A aborted by clr after 3 shifts, then a clean 80
      add(0,1,1,8'h5A,S0); add(0,1,0,8'h00,S1); add(0,1,0,8'h00,S0); add(0,1,0,8'h00,S1);
      add(1,1,1,8'hFF,IDL); add(0,1,1,8'h80,S1);
      for (int k = 0; k < 7; k++) add(0,1,0,8'h00,S0);
      add(0,1,0,8'h00,DN); add(0,0,0,8'h00,IDL);

      clr = 1'b1; ena = 1'b0; lv8 = 1'b0; lv2 = 1'b0; lv32 = 1'b0;
      d8 = '0; d2 = '0; d32 = '0;
      tick();
      clr = 1'b0;
      chk("reset_w2", 0, o2(), IDL);
      chk("reset_w32", 0, o32(), IDL);
      for (int k = 0; k < 10; k++) begin
         chk("reset_idle", k, o8(), IDL);
         tick();
      end

      foreach (tv[i]) begin
         clr = tv[i].c; ena = tv[i].e; lv8 = tv[i].lv; d8 = tv[i].d;
         tick();
         chk("table", i, o8(), tv[i].x);
      end
      clr = 1'b0; lv8 = 1'b0;

      // back-to-back: load_valid held high across FF then 01
      ena = 1'b1; lv8 = 1'b1; d8 = 8'hFF;
      tick(); chk("b2b_ff", 0, o8(), S1);
      d8 = 8'h01;
      for (int k = 1; k < 8; k++) begin
         tick(); chk("b2b_ff", k, o8(), S1);
      end
      tick(); chk("b2b_done", 0, o8(), DN);
      tick(); chk("b2b_gap", 0, o8(), IDL);
      tick(); chk("b2b_01", 0, o8(), S0);
      for (int k = 1; k < 7; k++) begin
         tick(); chk("b2b_01", k, o8(), S0);
      end
      tick(); chk("b2b_01", 7, o8(), S1);
      lv8 = 1'b0;
      tick(); chk("b2b_done", 1, o8(), DN);
      tick(); chk("b2b_idle", 0, o8(), IDL);

      // WIDTH=2
      lv2 = 1'b1; d2 = 2'b10;
      tick(); chk("w2", 0, o2(), S1);
      lv2 = 1'b0;
      tick(); chk("w2", 1, o2(), S0);
      tick(); chk("w2_done", 0, o2(), DN);
      tick(); chk("w2_idle", 0, o2(), IDL);

      // WIDTH=32
      w32 = 32'h8000_0001;
      lv32 = 1'b1; d32 = w32;
      tick(); chk("w32", 0, o32(), S1);
      lv32 = 1'b0; d32 = '0;
      for (int k = 1; k < 32; k++) begin
         tick(); chk("w32", k, o32(), {1'b0, w32[31-k], 3'b110});
      end
      tick(); chk("w32_done", 0, o32(), DN);
      tick(); chk("w32_idle", 0, o32(), IDL);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/shift_out_reg.md
# shift_out_reg

Parallel-in, serial-out transmit shifter: accepts a WIDTH-bit word through a valid/ready load handshake and emits it MSB-first on a single serial line, one bit per enabled clock edge. It is the transmit-side counterpart of the per-bit capture flip-flops in the datapath. It feeds any bit-serial consumer (debug/LED scan chains, serial peripheral links) that samples one bit per `ena` tick using the same clk/clr/ena convention.

## Interface
- WIDTH, 32, word length in bits; legal range 2..64.
- clk  input  1  single system clock; all state changes on posedge.
- clr  input  1  synchronous active-high reset; highest priority.
- ena  input  1  bit-advance enable (tick); the shift state holds when low.
- load_valid  input  1  producer has a word on load_data.
- load_data  input  WIDTH  word to transmit; bit WIDTH-1 is sent first.
- load_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out carries a live data bit.
- busy  output  1  a word is in flight (SHIFT or DONE).
- done  output  1  one-cycle pulse after the last bit is consumed.

## Operation
- Internal state: shreg[WIDTH-1:0], cnt[$clog2(WIDTH+1)-1:0], 2-bit FSM (IDLE, SHIFT, DONE).
- All registers power up to 0 (FSM = IDLE). Any FSM encoding outside the legal set returns to IDLE on the next edge.
- clr=1 at an edge: FSM→IDLE, shreg→0, cnt→0. This overrides load_valid and ena, including mid-word. The in-flight word is discarded and no done pulse is issued.
- IDLE:
  - load_ready=1, ser_valid=0, ser_out=0, busy=0.
  - If load_valid=1 at an edge: shreg←load_data, cnt←WIDTH, FSM→SHIFT.
  - ena has no effect in IDLE.
- SHIFT:
  - ser_out=shreg[WIDTH-1], ser_valid=1, busy=1, load_ready=0.
  - Edge with ena=1: shreg←{shreg[WIDTH-2:0],1'b0}, cnt←cnt-1. If cnt==1, FSM→DONE.
  - Edge with ena=0: all state holds.
- DONE:
  - done=1, busy=1, load_ready=0, ser_valid=0, ser_out=0.
  - Next edge goes unconditionally to IDLE. load_valid is ignored in DONE.
- Producer rules: load_data and load_valid may change freely while load_ready=0. They are sampled only on an edge where load_valid=1 and load_ready=1.
- All outputs are decoded from registered state only. No combinational path from inputs to outputs.

## Timing
- Reset values: load_ready=1, ser_out=0, ser_valid=0, busy=0, done=0.
- Load accepted at edge N: ser_out = load_data[WIDTH-1] and ser_valid=1 from cycle N+1.
- Bit k (k=0 is the MSB) is presented until the (k+1)-th edge in SHIFT with ena=1.
- With ena held high:
  - Bits occupy cycles N+1..N+WIDTH.
  - done is high in cycle N+WIDTH+1.
  - load_ready returns high in cycle N+WIDTH+2.
  - Minimum word-to-word spacing is WIDTH+2 cycles.
- ena stalls stretch the SHIFT phase by the number of ena=0 edges and do not disturb bit order.
- ena=1 on the accepting edge does not shift; the first shift is on the next edge.
- clr asserted in any cycle: outputs show reset values from the following cycle.

## Test plan
- Reset/idle, WIDTH=8: pulse clr, hold load_valid=0 → load_ready=1, ser_valid=0, busy=0, done=0 for 10 cycles.
- Basic word, WIDTH=8, ena=1, load 8'hA5 at edge N → ser_out = 1,0,1,0,0,1,0,1 in cycles N+1..N+8; done=1 only in N+9; load_ready=1 in N+10.
- Stalls, WIDTH=8, load 8'hC3, ena pattern 1,0,0,1,1,0,... → each bit holds across ena=0 cycles; serial sequence is still 1,1,0,0,0,0,1,1; done follows the 8th enabled edge by one cycle.
- Back-to-back, WIDTH=8: load_valid held high with 8'hFF then 8'h01 → second load accepted exactly at the first edge where load_ready=1; output is FF bits, idle/done gap, then 0,0,0,0,0,0,0,1; the second word is not accepted during DONE.
- Mid-word reset, WIDTH=8: load 8'h5A, assert clr after 3 enabled shifts → next cycle ser_valid=0, busy=0, load_ready=1; no done pulse; a new load of 8'h80 then transmits cleanly as 1,0,0,0,0,0,0,0.
- WIDTH=2 and WIDTH=32 builds: load 2'b10 and 32'h8000_0001 → correct MSB-first sequence; done after exactly 2 and 32 enabled edges.
